// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ALU op and branch-type encodings plus the default datapath width.
package riscv_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;
  typedef enum logic [2:0] {
    BR_NONE, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
  } br_type_e;
endpackage

// File: rtl/ex_alu.sv
// ex_alu: purely combinational integer ALU; shift amount is b[4:0].
module ex_alu
  import riscv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ALU_OP_W = 4
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic [XLEN-1:0]     y
);
  logic [4:0] sh;
  assign sh = b[4:0];
  always_comb begin
    y = '0;
    case (op)
      ALU_OP_W'(ALU_ADD):    y = a + b;
      ALU_OP_W'(ALU_SUB):    y = a - b;
      ALU_OP_W'(ALU_SLL):    y = a << sh;
      ALU_OP_W'(ALU_SLT):    y = XLEN'($signed(a) < $signed(b));
      ALU_OP_W'(ALU_SLTU):   y = XLEN'(a < b);
      ALU_OP_W'(ALU_XOR):    y = a ^ b;
      ALU_OP_W'(ALU_SRL):    y = a >> sh;
      ALU_OP_W'(ALU_SRA):    y = $signed(a) >>> sh;
      ALU_OP_W'(ALU_OR):     y = a | b;
      ALU_OP_W'(ALU_AND):    y = a & b;
      ALU_OP_W'(ALU_PASS_B): y = b;
      default:               y = '0;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand muxing, branch resolution and the EX/MEM register.
// Define EX_FORWARD_EN to forward EX/MEM and writeback results into rs1/rs2.
module ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fd_valid,
  input  logic [XLEN-1:0]     fd_pc,
  input  logic [4:0]          fd_rs1,
  input  logic [4:0]          fd_rs2,
  input  logic [4:0]          fd_rd,
  input  logic [XLEN-1:0]     fd_rs1_data,
  input  logic [XLEN-1:0]     fd_rs2_data,
  input  logic [XLEN-1:0]     fd_imm,
  input  logic [ALU_OP_W-1:0] fd_alu_op,
  input  logic                fd_a_sel_pc,
  input  logic                fd_b_sel_imm,
  input  logic [2:0]          fd_br_type,
  input  logic                fd_jal,
  input  logic                fd_jalr,
  input  logic                fd_reg_we,
  input  logic                fd_mem_read,
  input  logic                fd_mem_write,
  output logic                fd_ready,
  input  logic                mem_stall,
  input  logic                wb_we,
  input  logic [4:0]          wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_result,
  output logic [XLEN-1:0]     ex_store_data,
  output logic [4:0]          ex_rd,
  output logic                ex_reg_we,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  output logic                flush_fd
);
  logic            ex_valid_q, ex_valid_d, ex_reg_we_q, ex_reg_we_d;
  logic            ex_mem_read_q, ex_mem_read_d, ex_mem_write_q, ex_mem_write_d;
  logic            redirect_valid_q, redirect_valid_d, squash_q, squash_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d, ex_result_q, ex_result_d;
  logic [XLEN-1:0] ex_store_data_q, ex_store_data_d, redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] rs1_v, rs2_v, op_a, op_b, alu_y, target;
  logic            eq, lt, ltu, br_taken, squash, take;
`ifdef EX_FORWARD_EN
  logic fwd_ex;
  assign fwd_ex = ex_valid_q & ex_reg_we_q & !ex_mem_read_q;
  assign rs1_v = (fwd_ex && ex_rd_q == fd_rs1 && fd_rs1 != 5'd0) ? ex_result_q :
                 (wb_we && wb_rd == fd_rs1 && fd_rs1 != 5'd0) ? wb_data : fd_rs1_data;
  assign rs2_v = (fwd_ex && ex_rd_q == fd_rs2 && fd_rs2 != 5'd0) ? ex_result_q :
                 (wb_we && wb_rd == fd_rs2 && fd_rs2 != 5'd0) ? wb_data : fd_rs2_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{wb_we, wb_rd, wb_data, fd_rs1, fd_rs2};
  assign rs1_v = fd_rs1_data;
  assign rs2_v = fd_rs2_data;
`endif
  assign op_a = fd_a_sel_pc ? fd_pc : rs1_v;
  assign op_b = fd_b_sel_imm ? fd_imm : rs2_v;
  ex_alu #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W)) u_alu (.op(fd_alu_op), .a(op_a), .b(op_b), .y(alu_y));
  always_comb begin
    eq       = rs1_v == rs2_v;
    lt       = $signed(rs1_v) < $signed(rs2_v);
    ltu      = rs1_v < rs2_v;
    br_taken = fd_br_type == BR_BEQ  ? eq   :
               fd_br_type == BR_BNE  ? !eq  :
               fd_br_type == BR_BLT  ? lt   :
               fd_br_type == BR_BGE  ? !lt  :
               fd_br_type == BR_BLTU ? ltu  :
               fd_br_type == BR_BGEU ? !ltu : 1'b0;
    target   = fd_jalr ? ((rs1_v + fd_imm) & ~XLEN'(1)) : fd_pc + fd_imm;
    // a redirect seen during a stall still squashes the first instruction captured afterwards
    squash   = redirect_valid_q | squash_q;
    take     = !mem_stall & fd_valid & !squash & (fd_jal | fd_jalr | br_taken);
    squash_d         = mem_stall & squash;
    redirect_valid_d = take;
    redirect_pc_d    = take ? target : redirect_pc_q;
    ex_valid_d       = mem_stall ? ex_valid_q : fd_valid & !squash;
    ex_pc_d          = mem_stall ? ex_pc_q : fd_pc;
    ex_result_d      = mem_stall ? ex_result_q : (fd_jal | fd_jalr) ? fd_pc + XLEN'(4) : alu_y;
    ex_store_data_d  = mem_stall ? ex_store_data_q : rs2_v;
    ex_rd_d          = mem_stall ? ex_rd_q : fd_rd;
    ex_reg_we_d      = mem_stall ? ex_reg_we_q : fd_reg_we;
    ex_mem_read_d    = mem_stall ? ex_mem_read_q : fd_mem_read;
    ex_mem_write_d   = mem_stall ? ex_mem_write_q : fd_mem_write;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q       <= 1'b0;
      ex_pc_q          <= '0;
      ex_result_q      <= '0;
      ex_store_data_q  <= '0;
      ex_rd_q          <= '0;
      ex_reg_we_q      <= 1'b0;
      ex_mem_read_q    <= 1'b0;
      ex_mem_write_q   <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      squash_q         <= 1'b0;
    end else begin
      ex_valid_q       <= ex_valid_d;
      ex_pc_q          <= ex_pc_d;
      ex_result_q      <= ex_result_d;
      ex_store_data_q  <= ex_store_data_d;
      ex_rd_q          <= ex_rd_d;
      ex_reg_we_q      <= ex_reg_we_d;
      ex_mem_read_q    <= ex_mem_read_d;
      ex_mem_write_q   <= ex_mem_write_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      squash_q         <= squash_d;
    end
  end
  assign ex_valid       = ex_valid_q;
  assign ex_pc          = ex_pc_q;
  assign ex_result      = ex_result_q;
  assign ex_store_data  = ex_store_data_q;
  assign ex_rd          = ex_rd_q;
  assign ex_reg_we      = ex_reg_we_q;
  assign ex_mem_read    = ex_mem_read_q;
  assign ex_mem_write   = ex_mem_write_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_fd       = redirect_valid_q;
  assign fd_ready       = !mem_stall;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for ex_stage (checks forwarding when EX_FORWARD_EN is defined).
module tb_ex_stage;
  import riscv_pkg::*;
`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        fd_valid, fd_a_sel_pc, fd_b_sel_imm, fd_jal, fd_jalr;
  logic        fd_reg_we, fd_mem_read, fd_mem_write, fd_ready, mem_stall;
  logic [31:0] fd_pc, fd_rs1_data, fd_rs2_data, fd_imm, wb_data;
  logic [4:0]  fd_rs1, fd_rs2, fd_rd, wb_rd;
  logic [3:0]  fd_alu_op;
  logic [2:0]  fd_br_type;
  logic        wb_we;
  logic        ex_valid, ex_reg_we, ex_mem_read, ex_mem_write, redirect_valid, flush_fd;
  logic [31:0] ex_pc, ex_result, ex_store_data, redirect_pc;
  logic [4:0]  ex_rd;
  int vectors = 0, errors = 0;
  typedef struct {
    string       tag;
    logic        v, we, mr, mw, rv;
    logic [31:0] pc, res, st, rpc;
    logic [4:0]  rd;
  } exp_t;
  exp_t sbq[$];
  ex_stage dut (
    .clk(clk), .rst(rst), .fd_valid(fd_valid), .fd_pc(fd_pc), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
    .fd_rd(fd_rd), .fd_rs1_data(fd_rs1_data), .fd_rs2_data(fd_rs2_data), .fd_imm(fd_imm),
    .fd_alu_op(fd_alu_op), .fd_a_sel_pc(fd_a_sel_pc), .fd_b_sel_imm(fd_b_sel_imm),
    .fd_br_type(fd_br_type), .fd_jal(fd_jal), .fd_jalr(fd_jalr), .fd_reg_we(fd_reg_we),
    .fd_mem_read(fd_mem_read), .fd_mem_write(fd_mem_write), .fd_ready(fd_ready),
    .mem_stall(mem_stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_fd(flush_fd)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    {fd_valid, fd_a_sel_pc, fd_b_sel_imm, fd_jal, fd_jalr, fd_reg_we, fd_mem_read, fd_mem_write} = '0;
    {fd_pc, fd_rs1_data, fd_rs2_data, fd_imm} = '0;
    {fd_rs1, fd_rs2, fd_rd, fd_alu_op, fd_br_type} = '0;
  endtask
  task automatic instr(input logic [3:0] op, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm, input logic bsel);
    clr();
    fd_valid = 1'b1; fd_alu_op = op; fd_pc = pc; fd_rd = rd; fd_reg_we = 1'b1;
    fd_rs1_data = d1; fd_rs2_data = d2; fd_imm = imm; fd_b_sel_imm = bsel;
  endtask
  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] res,
                            input logic [31:0] st, input logic [4:0] rd, input logic we, input logic rv,
                            input logic [31:0] rpc = 0, input logic mr = 0, input logic mw = 0);
    exp_t e;
    e.tag = tag; e.v = v; e.pc = pc; e.res = res; e.st = st; e.rd = rd;
    e.we = we; e.rv = rv; e.rpc = rpc; e.mr = mr; e.mw = mw;
    sbq.push_back(e);
  endtask
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    chk({e.tag, ".valid"}, 32'(ex_valid), 32'(e.v));
    chk({e.tag, ".pc"}, ex_pc, e.pc);
    chk({e.tag, ".result"}, ex_result, e.res);
    chk({e.tag, ".store"}, ex_store_data, e.st);
    chk({e.tag, ".rd"}, 32'(ex_rd), 32'(e.rd));
    chk({e.tag, ".we"}, 32'({ex_reg_we, ex_mem_read, ex_mem_write}), 32'({e.we, e.mr, e.mw}));
    chk({e.tag, ".redirect"}, 32'(redirect_valid), 32'(e.rv));
    chk({e.tag, ".flush"}, 32'(flush_fd), 32'(e.rv));
    if (e.rv) chk({e.tag, ".rpc"}, redirect_pc, e.rpc);
  endtask
  initial begin
    clr();
    mem_stall = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    #3;
    chk("rst.valid", 32'({ex_valid, ex_reg_we, ex_mem_read, ex_mem_write, redirect_valid}), 32'd0);
    chk("rst.data", ex_pc | ex_result | ex_store_data | redirect_pc | 32'(ex_rd), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    instr(ALU_ADD, 32'h0, 5'd3, 32'h7FFFFFFF, 32'h1, 0, 0);
    expect_out("add_ovf", 1, 32'h0, 32'h80000000, 32'h1, 3, 1, 0); tick();
    instr(ALU_SUB, 32'h4, 5'd4, 32'd5, 32'd7, 0, 0);
    expect_out("sub", 1, 32'h4, 32'hFFFFFFFE, 32'd7, 4, 1, 0); tick();
    instr(ALU_SRA, 32'h8, 5'd4, 32'h80000000, 32'h55, 32'd4, 1);
    expect_out("sra", 1, 32'h8, 32'hF8000000, 32'h55, 4, 1, 0); tick();
    instr(ALU_SLT, 32'hC, 5'd4, 32'hFFFFFFFF, 32'h1, 0, 0);
    expect_out("slt", 1, 32'hC, 32'h1, 32'h1, 4, 1, 0); tick();
    instr(ALU_SLTU, 32'h10, 5'd4, 32'hFFFFFFFF, 32'h1, 0, 0);
    expect_out("sltu", 1, 32'h10, 32'h0, 32'h1, 4, 1, 0); tick();
    instr(ALU_SLL, 32'h14, 5'd4, 32'h1, 32'h3F, 0, 0);
    expect_out("sll", 1, 32'h14, 32'h80000000, 32'h3F, 4, 1, 0); tick();
    instr(ALU_SRL, 32'h18, 5'd4, 32'h80000000, 32'h21, 0, 0);
    expect_out("srl", 1, 32'h18, 32'h40000000, 32'h21, 4, 1, 0); tick();
    instr(ALU_XOR, 32'h1C, 5'd4, 32'hF0F0, 32'hFF00, 0, 0);
    expect_out("xor", 1, 32'h1C, 32'h0FF0, 32'hFF00, 4, 1, 0); tick();
    instr(ALU_OR, 32'h20, 5'd4, 32'hF0F0, 32'hFF00, 0, 0);
    expect_out("or", 1, 32'h20, 32'hFFF0, 32'hFF00, 4, 1, 0); tick();
    instr(ALU_AND, 32'h24, 5'd4, 32'hF0F0, 32'hFF00, 0, 0);
    expect_out("and", 1, 32'h24, 32'hF000, 32'hFF00, 4, 1, 0); tick();
    instr(ALU_PASS_B, 32'h28, 5'd4, 32'h1, 32'h2, 32'hABC, 1);
    expect_out("passb", 1, 32'h28, 32'hABC, 32'h2, 4, 1, 0); tick();
    instr(ALU_ADD, 32'h1000, 5'd4, 32'h1, 32'h2, 32'h10, 1); fd_a_sel_pc = 1'b1;
    expect_out("auipc", 1, 32'h1000, 32'h1010, 32'h2, 4, 1, 0); tick();
    instr(ALU_ADD, 32'h2C, 5'd5, 32'h100, 32'h0, 32'h8, 1); fd_mem_read = 1'b1;
    expect_out("load", 1, 32'h2C, 32'h108, 32'h0, 5, 1, 0, 0, 1, 0); tick();
    instr(ALU_ADD, 32'h100, 5'd0, 32'd5, 32'd5, 32'h20, 0); fd_reg_we = 1'b0; fd_br_type = BR_BEQ;
    expect_out("beq", 1, 32'h100, 32'hA, 32'd5, 0, 0, 1, 32'h120); tick();
    instr(ALU_ADD, 32'h200, 5'd1, 0, 0, 32'h40, 1); fd_jal = 1'b1;
    expect_out("squash_jal", 0, 32'h200, 32'h204, 32'h0, 1, 1, 0); tick();
    instr(ALU_ADD, 32'h208, 5'd6, 32'd2, 32'd3, 0, 0);
    expect_out("after_squash", 1, 32'h208, 32'd5, 32'd3, 6, 1, 0); tick();
    instr(ALU_ADD, 32'h20C, 5'd0, 32'd9, 32'd9, 32'h40, 0); fd_reg_we = 1'b0; fd_br_type = BR_BNE;
    expect_out("bne_nt", 1, 32'h20C, 32'd18, 32'd9, 0, 0, 0); tick();
    instr(ALU_ADD, 32'h300, 5'd0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFF0, 0); fd_reg_we = 1'b0; fd_br_type = BR_BLT;
    expect_out("blt", 1, 32'h300, 32'h0, 32'h1, 0, 0, 1, 32'h2F0); tick();
    clr();
    expect_out("bubble1", 0, 0, 0, 0, 0, 0, 0); tick();
    instr(ALU_ADD, 32'h400, 5'd0, 32'd1, 32'd1, 32'h40, 0); fd_reg_we = 1'b0; fd_br_type = BR_BGEU; fd_valid = 1'b0;
    expect_out("invalid_bgeu", 0, 32'h400, 32'd2, 32'd1, 0, 0, 0); tick();
    instr(ALU_ADD, 32'h404, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h40, 0); fd_reg_we = 1'b0; fd_br_type = BR_BLTU;
    expect_out("bltu_nt", 1, 32'h404, 32'h0, 32'h1, 0, 0, 0); tick();
    instr(ALU_ADD, 32'h408, 5'd0, 32'h1, 32'hFFFFFFFF, 32'h8, 0); fd_reg_we = 1'b0; fd_br_type = BR_BGE;
    expect_out("bge", 1, 32'h408, 32'h0, 32'hFFFFFFFF, 0, 0, 1, 32'h410); tick();
    clr();
    expect_out("bubble2", 0, 0, 0, 0, 0, 0, 0); tick();
    instr(ALU_ADD, 32'h40, 5'd1, 32'h1003, 32'h0, 32'h0, 1); fd_jalr = 1'b1;
    expect_out("jalr", 1, 32'h40, 32'h44, 32'h0, 1, 1, 1, 32'h1002); tick();
    clr();
    expect_out("bubble3", 0, 0, 0, 0, 0, 0, 0); tick();
    instr(ALU_ADD, 32'h500, 5'd7, 32'd10, 32'd20, 0, 0); fd_reg_we = 1'b0; fd_mem_write = 1'b1;
    expect_out("store", 1, 32'h500, 32'd30, 32'd20, 7, 0, 0, 0, 0, 1); tick();
    mem_stall = 1'b1;
    instr(ALU_ADD, 32'h504, 5'd8, 32'd1, 32'd1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_out("stall_hold", 1, 32'h500, 32'd30, 32'd20, 7, 0, 0, 0, 0, 1); tick();
      chk("stall_ready", 32'(fd_ready), 32'd0);
    end
    mem_stall = 1'b0;
    expect_out("resume", 1, 32'h504, 32'd2, 32'd1, 8, 1, 0); tick();
    chk("resume_ready", 32'(fd_ready), 32'd1);
    instr(ALU_ADD, 32'h600, 5'd1, 0, 0, 32'h100, 1); fd_jal = 1'b1;
    expect_out("jal", 1, 32'h600, 32'h604, 32'h0, 1, 1, 1, 32'h700); tick();
    mem_stall = 1'b1;
    instr(ALU_ADD, 32'h700, 5'd2, 0, 0, 32'h8, 1); fd_jal = 1'b1;
    expect_out("stall_redirect", 1, 32'h600, 32'h604, 32'h0, 1, 1, 0); tick();
    mem_stall = 1'b0;
    expect_out("late_squash", 0, 32'h700, 32'h704, 32'h0, 2, 1, 0); tick();
    instr(ALU_ADD, 32'h704, 5'd3, 32'd4, 32'd4, 0, 0);
    expect_out("post_late_squash", 1, 32'h704, 32'd8, 32'd4, 3, 1, 0); tick();
    instr(ALU_ADD, 32'h800, 5'd1, 0, 0, 32'h10, 1); fd_jal = 1'b1;
    expect_out("jal_pre_rst", 1, 32'h800, 32'h804, 32'h0, 1, 1, 1, 32'h810); tick();
    rst = 1'b1;
    #1;
    chk("mid_rst.redirect", 32'({redirect_valid, flush_fd, ex_valid}), 32'd0);
    chk("mid_rst.data", ex_pc | ex_result | redirect_pc, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    instr(ALU_ADD, 32'h900, 5'd9, 32'd6, 32'd7, 0, 0);
    expect_out("post_rst", 1, 32'h900, 32'd13, 32'd7, 9, 1, 0); tick();
    instr(ALU_ADD, 32'h0, 5'd1, 32'd3, 32'd0, 0, 0);
    expect_out("fwd_src", 1, 32'h0, 32'd3, 32'd0, 1, 1, 0); tick();
    instr(ALU_ADD, 32'h4, 5'd2, 32'd0, 32'd0, 0, 0); fd_rs1 = 5'd1; fd_rs2 = 5'd1;
    expect_out("fwd_ex", 1, 32'h4, FWD ? 32'd6 : 32'd0, FWD ? 32'd3 : 32'd0, 2, 1, 0); tick();
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h99;
    instr(ALU_ADD, 32'h8, 5'd3, 32'd4, 32'd5, 0, 0);
    expect_out("wb_x0", 1, 32'h8, 32'd9, 32'd5, 3, 1, 0); tick();
    wb_rd = 5'd5;
    instr(ALU_ADD, 32'hC, 5'd4, 32'd1, 32'd2, 0, 0); fd_rs1 = 5'd5;
    expect_out("fwd_wb", 1, 32'hC, FWD ? 32'h9B : 32'd3, 32'd2, 4, 1, 0); tick();
    wb_we = 1'b0;
    clr();
    expect_out("final", 0, 0, 0, 0, 0, 0, 0); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL have parameter ALU_OP_W, default 4, width of the ALU opcode field.
REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have FD-side inputs:
- fd_valid (1)
- fd_pc (XLEN)
- fd_rs1, fd_rs2, fd_rd (5 each)
- fd_rs1_data, fd_rs2_data, fd_imm (XLEN each)
- fd_alu_op (ALU_OP_W)
- fd_a_sel_pc (1), fd_b_sel_imm (1)
- fd_br_type (3)
- fd_jal (1), fd_jalr (1)
- fd_reg_we (1), fd_mem_read (1), fd_mem_write (1)
REQ-006 SHALL have port fd_ready, output, 1: FD may advance; equals !mem_stall.
REQ-007 SHALL have port mem_stall, input, 1: downstream hold request.
REQ-008 SHALL have writeback inputs wb_we (1), wb_rd (5), wb_data (XLEN).
REQ-009 SHALL have EX/MEM register outputs:
- ex_valid (1), ex_pc (XLEN), ex_result (XLEN), ex_store_data (XLEN)
- ex_rd (5), ex_reg_we (1), ex_mem_read (1), ex_mem_write (1)
REQ-010 SHALL have outputs redirect_valid (1) and redirect_pc (XLEN): fetch redirect pulse and target.
REQ-011 SHALL have port flush_fd, output, 1: discard FD contents; equals redirect_valid.

Function
REQ-012 SHALL support these ALU ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B.
- Shift amount is operand B[4:0].
- SLT/SLTU produce 0 or 1.
REQ-013 SHALL select operands:
- Operand A: fd_pc when fd_a_sel_pc, else rs1 value.
- Operand B: fd_imm when fd_b_sel_imm, else rs2 value.
REQ-014 SHALL, when fd_jal or fd_jalr, make ex_result = pc+4 (wrapping modulo 2^XLEN).
REQ-015 SHALL evaluate fd_br_type as NONE, BEQ, BNE, BLT, BGE, BLTU, BGEU on the rs1/rs2 values (signed or unsigned as named).
REQ-016 SHALL compute the control-transfer target:
- Taken branch or JAL: pc+imm.
- JALR: (rs1+imm) with bit 0 cleared.
- Bit 1 is passed through unchanged; no misalignment exception.
REQ-017 SHALL, on a rising edge with !mem_stall, capture all EX/MEM outputs.
- ex_valid <= fd_valid & !redirect_valid.
- ex_store_data <= rs2 value.
REQ-018 SHALL hold all EX/MEM outputs unchanged while mem_stall=1.
REQ-019 SHALL give one-cycle latency: FD inputs on edge N appear on outputs after edge N.
REQ-020 SHALL pulse redirect_valid high for exactly one cycle after capturing a valid taken branch, JAL or JALR; redirect_pc is registered with it.
REQ-021 SHALL treat the FD instruction presented while redirect_valid=1 as wrong-path and squash it.
- ex_valid <= 0.
- No redirect is produced from it, even if it is itself taken.
REQ-022 SHALL produce no redirect when the captured instruction has fd_valid=0.
REQ-023 SHALL make a stall coincident with redirect_valid extend neither the pulse nor the squash; the squash applies at the next capture edge.

Reset
REQ-024 SHALL, while rst=1, immediately force:
- ex_valid, ex_reg_we, ex_mem_read, ex_mem_write, redirect_valid to 0.
- ex_pc, ex_result, ex_store_data, redirect_pc, ex_rd to 0.
REQ-025 SHALL discard an in-flight instruction or pending redirect on reset asserted mid-operation; the first capture after deassertion is a normal capture.

Configuration
REQ-026 SHALL, with EX_FORWARD_EN defined, replace the rs1 and rs2 values by forwarded data, with rd=0 never forwarded:
- Priority 1, EX/MEM register: when ex_valid & ex_reg_we & !ex_mem_read & ex_rd==rs & rs!=0.
- Priority 2, writeback: when wb_we & wb_rd==rs & rs!=0.
- Otherwise: fd_rs*_data.
REQ-027 SHALL, without EX_FORWARD_EN, use fd_rs1_data and fd_rs2_data unmodified; the wb_* inputs are unused.

Structure
REQ-028 SHALL take ALU op and branch-type encodings, plus the XLEN default, from shared package riscv_pkg.
REQ-029 SHALL put ALU arithmetic in sub-module ex_alu (purely combinational); ex_stage holds operand muxing, branch resolution, forwarding and registers.

Verification
REQ-030 SHALL cover: ADD with rs1=0x7FFFFFFF and rs2=1 -> ex_result=0x80000000 one cycle later, ex_valid=1.
REQ-031 SHALL cover: BEQ at pc=0x100 with imm=0x20, rs1=rs2=5:
- redirect_valid=1 for one cycle with redirect_pc=0x120.
- The next FD instruction is squashed (ex_valid=0).
REQ-032 SHALL cover: JALR at pc=0x40 with rs1=0x1003, imm=0 -> redirect_pc=0x1002 and ex_result=0x44.
REQ-033 SHALL cover: mem_stall=1 for 3 cycles with new FD inputs -> outputs frozen, fd_ready=0; the resumed capture is correct.
REQ-034 SHALL cover, with EX_FORWARD_EN, back-to-back ADD x1 then ADD x2,x1,x1 with x1=3 -> second ex_result=6; with a wb write to x0 -> no forwarding.
REQ-035 SHALL cover: rst asserted during redirect_valid=1 -> redirect_valid=0 immediately with no pulse after release.
